// File: rtl/key_scan.sv
`default_nettype none
// =============================================================================
// key_scan : 4x4 active-low key matrix scanner with frame debounce and
//            row-0 game-key encoder driving state_no.
// Revision : 1.0
// =============================================================================
module key_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [5:0] state_no
);

    localparam int                   c_dwell_w    = $clog2(SCAN_DIV);
    localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(SCAN_DIV - 1);
    localparam logic [c_dwell_w-1:0] c_dwell_one  = c_dwell_w'(1);
    localparam logic [7:0]           c_deb_thresh = 8'(DEBOUNCE_SCANS);
    localparam logic [7:0]           c_cnt_max    = 8'd255;

    typedef enum logic [1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        ROW2 = 2'd2,
        ROW3 = 2'd3
    } row_state_e;

    // Column synchroniser
    logic [3:0]           col_meta_q;
    logic [3:0]           col_sync_q;

    // Row scan FSM
    row_state_e           state_q;
    logic [c_dwell_w-1:0] dwell_q;
    logic [3:0]           row_q;

    // Rows 0..2 of the frame in progress; row 3 joins combinationally at frame end
    logic [11:0]          snapshot_q;

    // Debounce state
    logic [15:0]          prev_q,   prev_d;
    logic [15:0]          deb_q,    deb_d;
    logic [7:0]           stable_q, stable_d;

    // Registered outputs
    logic                 key_valid_q, key_valid_d;
    logic [3:0]           key_code_q,  key_code_d;
    logic [5:0]           state_no_q,  state_no_d;

    logic [3:0]           w_pressed;
    logic                 w_sample;
    logic                 w_frame_end;
    logic [15:0]          w_frame;
    logic [15:0]          w_press;
    logic [3:0]           w_low_idx;
    logic                 w_commit;

    function automatic logic [5:0] f_encode(input logic [3:0] k);
        if (k[0]) return 6'd1;
        if (k[1]) return 6'd2;
        if (k[2]) return 6'd3;
        if (k[3]) return 6'd4;
        return 6'd0;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta_q <= 4'b1111;
            col_sync_q <= 4'b1111;
        end else begin
            col_meta_q <= col;
            col_sync_q <= col_meta_q;
        end
    end

    assign w_pressed   = ~col_sync_q;
    assign w_sample    = (dwell_q == c_dwell_last);
    assign w_frame_end = w_sample && (state_q == ROW3);
    assign w_frame     = {w_pressed, snapshot_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ROW0;
            dwell_q    <= '0;
            row_q      <= 4'b1110;
            snapshot_q <= '0;
        end else if (w_sample) begin
            dwell_q <= '0;
            case (state_q)
                ROW0: begin
                    snapshot_q[3:0] <= w_pressed;
                    state_q         <= ROW1;
                    row_q           <= 4'b1101;
                end
                ROW1: begin
                    snapshot_q[7:4] <= w_pressed;
                    state_q         <= ROW2;
                    row_q           <= 4'b1011;
                end
                ROW2: begin
                    snapshot_q[11:8] <= w_pressed;
                    state_q          <= ROW3;
                    row_q            <= 4'b0111;
                end
                default: begin
                    state_q <= ROW0;
                    row_q   <= 4'b1110;
                end
            endcase
        end else begin
            dwell_q <= dwell_q + c_dwell_one;
        end
    end

    always_comb begin
        prev_d   = prev_q;
        deb_d    = deb_q;
        stable_d = stable_q;
        w_commit = 1'b0;
        if (w_frame_end) begin
            if (w_frame == prev_q) begin
                stable_d = (stable_q == c_cnt_max) ? c_cnt_max : stable_q + 8'd1;
            end else begin
                stable_d = 8'd1;
            end
            prev_d   = w_frame;
            w_commit = (stable_d >= c_deb_thresh) && (w_frame != deb_q);
            if (w_commit) begin
                deb_d = w_frame;
            end
        end
    end

    // Only keys newly closed relative to the committed vector count as presses
    assign w_press = w_frame & ~deb_q;

    always_comb begin
        w_low_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (w_press[i]) begin
                w_low_idx = 4'(i);
            end
        end
    end

    always_comb begin
        key_valid_d = w_commit && (w_press != 16'h0);
        key_code_d  = key_valid_d ? w_low_idx : key_code_q;
        state_no_d  = w_commit ? f_encode(w_frame[3:0]) : state_no_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q      <= '0;
            deb_q       <= '0;
            stable_q    <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            state_no_q  <= '0;
        end else begin
            prev_q      <= prev_d;
            deb_q       <= deb_d;
            stable_q    <= stable_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            state_no_q  <= state_no_d;
        end
    end

    assign row       = row_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign state_no  = state_no_q;

endmodule
`default_nettype wire

// File: tb/tb_key_scan.sv
`default_nettype none
// =============================================================================
// tb_key_scan : directed bench for key_scan with a key-matrix model and an
//               event scoreboard (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// Revision    : 1.0
// =============================================================================
module tb_key_scan;

    logic        clk;
    logic        rst;
    logic [3:0]  col;
    logic [3:0]  row;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [5:0]  state_no;
    logic [15:0] keys;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc;

    typedef struct {
        logic [3:0] code;
        logic [5:0] st;
        int         at;
    } exp_t;
    exp_t exp_q[$];

    key_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .key_valid (key_valid),
        .key_code  (key_code),
        .state_no  (state_no)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index since reset release; cycle 0 precedes the first edge
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Matrix model: a closed key pulls its column low while its row is driven
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row[r] && keys[4*r+c]) col[c] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && key_valid === 1'b1) begin
            n_assert++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_pulse: observed key_valid=1 code %0d at cycle %0d expected no pulse", key_code, cyc);
            end
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_code",  32'(key_code), 32'(e.code));
                chk("pulse_state", 32'(state_no), 32'(e.st));
                chk("pulse_cycle", 32'(cyc),      32'(e.at));
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset(input logic [15:0] k);
        @(negedge clk);
        rst  = 1'b1;
        keys = k;
        repeat (2) @(negedge clk);
        chk("rst_row",       32'(row),       32'(4'b1110));
        chk("rst_key_valid", 32'(key_valid), 32'(0));
        chk("rst_key_code",  32'(key_code),  32'(0));
        chk("rst_state_no",  32'(state_no),  32'(0));
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] er;
        rst  = 1'b1;
        keys = 16'h0;

        // Idle scan: row sequence and no events over 10 frames
        do_reset(16'h0000);
        for (int c = 0; c < 20; c++) begin
            er = ~(4'b0001 << ((c / 4) % 4));
            chk("row_seq", 32'(row), 32'(er));
            @(negedge clk);
        end
        wait_until(160);
        chk("idle_state_no", 32'(state_no), 32'(0));

        // Key 0 from reset: commit on frame 3, pulse in cycle 48
        do_reset(16'h0001);
        exp_q.push_back('{code: 4'd0, st: 6'd1, at: 48});
        wait_until(47);
        chk("k0_pre_state", 32'(state_no), 32'(0));
        wait_until(50);
        chk("k0_events_seen", 32'(exp_q.size()), 32'(0));
        wait_until(60);
        keys = 16'h0000;
        wait_until(111);
        chk("k0_hold_state", 32'(state_no), 32'(1));
        wait_until(112);
        chk("k0_release_state", 32'(state_no), 32'(0));
        chk("k0_release_code",  32'(key_code), 32'(0));

        // Key 2 bounce (two frames) is rejected, then a steady press commits
        do_reset(16'h0000);
        wait_until(16);
        keys = 16'h0004;
        wait_until(48);
        keys = 16'h0000;
        wait_until(95);
        chk("k2_bounce_state", 32'(state_no), 32'(0));
        chk("k2_bounce_code",  32'(key_code), 32'(0));
        keys = 16'h0004;
        exp_q.push_back('{code: 4'd2, st: 6'd3, at: 144});
        wait_until(146);
        chk("k2_events_seen", 32'(exp_q.size()), 32'(0));
        chk("k2_state", 32'(state_no), 32'(3));

        // Keys 1 and 3 together: one event for the lowest, then release key 1
        do_reset(16'h0000);
        wait_until(16);
        keys = 16'h000A;
        exp_q.push_back('{code: 4'd1, st: 6'd2, at: 64});
        wait_until(66);
        chk("k13_events_seen", 32'(exp_q.size()), 32'(0));
        wait_until(80);
        keys = 16'h0008;
        wait_until(127);
        chk("k13_hold_state", 32'(state_no), 32'(2));
        wait_until(128);
        chk("k3_only_state", 32'(state_no), 32'(4));
        chk("k3_only_code",  32'(key_code), 32'(1));

        // Key 9 is outside row 0: reported but state_no stays IDLE
        do_reset(16'h0000);
        wait_until(16);
        keys = 16'h0200;
        exp_q.push_back('{code: 4'd9, st: 6'd0, at: 64});
        wait_until(70);
        chk("k9_events_seen", 32'(exp_q.size()), 32'(0));
        chk("k9_code",  32'(key_code), 32'(9));
        chk("k9_state", 32'(state_no), 32'(0));

        // Asynchronous reset mid-ROW2 with key 0 committed, then re-commit
        do_reset(16'h0001);
        exp_q.push_back('{code: 4'd0, st: 6'd1, at: 48});
        wait_until(57);
        chk("mid_row2", 32'(row), 32'(4'b1011));
        chk("mid_state", 32'(state_no), 32'(1));
        rst = 1'b1;
        #1;
        chk("async_row",       32'(row),       32'(4'b1110));
        chk("async_state_no",  32'(state_no),  32'(0));
        chk("async_key_code",  32'(key_code),  32'(0));
        chk("async_key_valid", 32'(key_valid), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back('{code: 4'd0, st: 6'd1, at: 48});
        wait_until(47);
        chk("recommit_pre_state", 32'(state_no), 32'(0));
        wait_until(50);
        chk("recommit_events_seen", 32'(exp_q.size()), 32'(0));
        chk("recommit_state", 32'(state_no), 32'(1));

        repeat (4) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
